// File: rtl/ibex_mem_arb_pkg.sv
// Shared types and helpers for the ibex single-port memory arbiter.
// Holds the response tag layout and the SRAM window decode.
package ibex_mem_arb_pkg;

    typedef enum logic {
        ArbFixed,
        ArbRoundRobin
    } arb_mode_e;

    // Tag index is sized for the largest supported port count.
    localparam int MaxPortsW = 4;
    localparam int MaxAddrW  = 64;

    typedef struct packed {
        logic                 valid;
        logic [MaxPortsW-1:0] idx;
        logic                 err;
    } resp_tag_t;

    // Window size is a power of two, so masking the offset bits leaves the base.
    function automatic logic in_window(input logic [MaxAddrW-1:0] addr,
                                       input logic [MaxAddrW-1:0] base,
                                       input logic [MaxAddrW-1:0] size);
        return (addr & ~(size - 1'b1)) == base;
    endfunction

endpackage

// File: rtl/ibex_rr_arbiter.sv
// One-hot request arbiter with either fixed lowest-index priority or a
// rotating priority pointer that moves past the most recent winner.
module ibex_rr_arbiter
    import ibex_mem_arb_pkg::*;
#(
    parameter int NumPorts   = 2,
    parameter int RoundRobin = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NumPorts-1:0] req,
    input  logic                advance,
    output logic [NumPorts-1:0] gnt
);

    localparam int        IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam arb_mode_e Mode = (RoundRobin != 0) ? ArbRoundRobin : ArbFixed;

    logic [IdxW-1:0] prio_q;
    logic [IdxW-1:0] win;
    logic            found;
    int              cand;

    // Scan all ports once, starting at the priority pointer and wrapping.
    always_comb begin
        gnt   = '0;
        win   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NumPorts; i++) begin
            cand = int'(prio_q) + i;
            if (cand >= NumPorts) cand = cand - NumPorts;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                win       = IdxW'(cand);
            end
        end
    end

    // In fixed mode the pointer never leaves zero, so the scan starts at port 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= '0;
        end else if (Mode == ArbRoundRobin && advance && found) begin
            prio_q <= (win == IdxW'(NumPorts - 1)) ? '0 : win + 1'b1;
        end
    end

endmodule

// File: rtl/ibex_mem_arbiter.sv
// N-port arbiter in front of one single-port SRAM: window decode, request mux,
// latency-matched tag pipeline and response demux back to the requester.
module ibex_mem_arbiter
    import ibex_mem_arb_pkg::*;
#(
    parameter int                   NumPorts   = 2,
    parameter int                   AddrWidth  = 32,
    parameter int                   DataWidth  = 32,
    parameter logic [AddrWidth-1:0] MemStart   = '0,
    parameter int unsigned          MemSize    = 8 * 1024,
    parameter int                   RoundRobin = 0,
    parameter int                   MemLatency = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumPorts-1:0]             req_i,
    input  logic [NumPorts-1:0]             we_i,
    input  logic [NumPorts*DataWidth/8-1:0] be_i,
    input  logic [NumPorts*AddrWidth-1:0]   addr_i,
    input  logic [NumPorts*DataWidth-1:0]   wdata_i,
    output logic [NumPorts-1:0]             gnt_o,
    output logic [NumPorts-1:0]             rvalid_o,
    output logic [NumPorts-1:0]             err_o,
    output logic [DataWidth-1:0]            rdata_o,
    output logic                            mem_req_o,
    output logic                            mem_we_o,
    output logic [DataWidth/8-1:0]          mem_be_o,
    output logic [AddrWidth-1:0]            mem_addr_o,
    output logic [DataWidth-1:0]            mem_wdata_o,
    input  logic                            mem_rvalid_i,
    input  logic [DataWidth-1:0]            mem_rdata_i
);

    localparam int IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int BeW  = DataWidth / 8;

    logic [NumPorts-1:0]  gnt;
    logic                 any_gnt;
    logic                 win_ok;
    logic [IdxW-1:0]      win_idx;
    logic                 win_we;
    logic [BeW-1:0]       win_be;
    logic [AddrWidth-1:0] win_addr;
    logic [DataWidth-1:0] win_wdata;
    resp_tag_t            tag_in;
    resp_tag_t            tag_q [MemLatency];
    resp_tag_t            tag_out;

    ibex_rr_arbiter #(
        .NumPorts  (NumPorts),
        .RoundRobin(RoundRobin)
    ) u_arb (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .req    (req_i),
        .advance(|req_i),
        .gnt    (gnt)
    );

    assign gnt_o   = gnt;
    assign any_gnt = |gnt;

    // Grant is one-hot, so a priority-free select is enough.
    always_comb begin
        win_idx   = '0;
        win_we    = 1'b0;
        win_be    = '0;
        win_addr  = '0;
        win_wdata = '0;
        for (int k = 0; k < NumPorts; k++) begin
            if (gnt[k]) begin
                win_idx   = IdxW'(k);
                win_we    = we_i[k];
                win_be    = be_i[k*BeW +: BeW];
                win_addr  = addr_i[k*AddrWidth +: AddrWidth];
                win_wdata = wdata_i[k*DataWidth +: DataWidth];
            end
        end
    end

    assign win_ok = any_gnt & in_window(MaxAddrW'(win_addr), MaxAddrW'(MemStart),
                                        MaxAddrW'(MemSize));

    assign mem_req_o   = win_ok;
    assign mem_we_o    = win_ok & win_we;
    assign mem_be_o    = win_ok ? win_be    : '0;
    assign mem_addr_o  = win_ok ? win_addr  : '0;
    assign mem_wdata_o = win_ok ? win_wdata : '0;

    // Out-of-window winners travel the same pipeline so responses stay in order.
    assign tag_in = '{valid: any_gnt,
                      idx:   MaxPortsW'(win_idx),
                      err:   any_gnt & ~win_ok};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MemLatency; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < MemLatency; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign tag_out = tag_q[MemLatency-1];

    always_comb begin
        rvalid_o = '0;
        err_o    = '0;
        rdata_o  = '0;
        for (int k = 0; k < NumPorts; k++) begin
            if (tag_out.valid && tag_out.idx == MaxPortsW'(k)) begin
                rvalid_o[k] = tag_out.err | mem_rvalid_i;
                err_o[k]    = tag_out.err;
            end
        end
        if (tag_out.valid && !tag_out.err) rdata_o = mem_rdata_i;
    end

`ifndef SYNTHESIS
    // The SRAM must answer every in-window access exactly MemLatency cycles later.
    mem_rvalid_missing: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (tag_out.valid && !tag_out.err) |-> mem_rvalid_i);
`endif

endmodule
